// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache with one-word lines.
// Hits are served combinationally; a miss performs a single-word fill over the iREN/iwait channel.
module icache_direct #(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iflush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    typedef enum logic {
        IDLE,
        MISS
    } state_t;

    state_t state, next_state;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags [SETS];
    logic [31:0]      data [SETS];
    logic [31:0]      miss_addr;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] miss_idx;
    logic [TAG_W-1:0] miss_tag;

    logic hit;
    logic start_miss;
    logic fill;

    // Byte-offset bits of both addresses never reach the array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imemaddr[1:0], miss_addr[1:0]};

    assign req_idx  = imemaddr[IDX_W+1:2];
    assign req_tag  = imemaddr[31:IDX_W+2];
    assign miss_idx = miss_addr[IDX_W+1:2];
    assign miss_tag = miss_addr[31:IDX_W+2];

    always_comb begin
        next_state = state;
        hit        = 1'b0;
        start_miss = 1'b0;
        fill       = 1'b0;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        case (state)
            IDLE: begin
                hit      = imemREN && !iflush && valid[req_idx] && (tags[req_idx] == req_tag);
                ihit     = hit;
                imemload = hit ? data[req_idx] : '0;
                if (imemREN && !hit && !iflush) begin
                    start_miss = 1'b1;
                    next_state = MISS;
                end
            end
            MISS: begin
                iREN  = 1'b1;
                iaddr = miss_addr;
                // A flush in the completing cycle discards the returning word.
                if (iflush) begin
                    next_state = IDLE;
                end else if (!iwait) begin
                    fill       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            valid      <= '0;
            miss_addr  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            for (int unsigned i = 0; i < SETS; i++) begin
                tags[i] <= '0;
                data[i] <= '0;
            end
        end else begin
            state <= next_state;
            if (iflush) begin
                valid <= '0;
            end else if (fill) begin
                valid[miss_idx] <= 1'b1;
                tags[miss_idx]  <= miss_tag;
                data[miss_idx]  <= iload;
            end
            if (hit) begin
                hit_count <= hit_count + 32'd1;
            end
            if (start_miss) begin
                miss_addr  <= {imemaddr[31:2], 2'b00};
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the CPU fetch stage and the instruction port of memory_control.
- Serves instruction fetches in the same cycle on a hit.
- On a miss, issues a single-word read on the iREN/iaddr/iload/iwait channel, fills the line, then serves the fetch.
- Provides whole-cache invalidate and hit/miss statistics counters.

Parameters:
- SETS, 16, number of one-word lines; power of two, 2..256.
- IDX_W, $clog2(SETS), index width (derived, not overridden).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset; synchronous, active-low.
- imemREN  in  1  CPU fetch request.
- imemaddr  in  32  CPU fetch byte address; bits [1:0] ignored.
- ihit  out  1  fetch satisfied this cycle.
- imemload  out  32  instruction word; valid when ihit=1, else 0.
- iflush  in  1  invalidate all lines.
- iREN  out  1  read request to memory_control.
- iaddr  out  32  word-aligned read address to memory_control.
- iload  in  32  read data from memory_control.
- iwait  in  1  memory_control busy; data is valid in a cycle with iREN=1 and iwait=0.
- hit_count  out  32  fetches completed as hits since reset; wraps.
- miss_count  out  32  misses since reset; wraps.

Behaviour:
- Address split:
  - index = imemaddr[IDX_W+1:2]
  - tag = imemaddr[31:IDX_W+2]
  - Per line: valid bit, tag, 32-bit data.
- Reset (nRST=0 at an edge):
  - Synchronous; takes priority over all other inputs and overrides any in-flight miss.
  - State → IDLE; all valid bits, tags and data cleared to 0.
  - miss_addr and both counters cleared to 0.
  - Combinational outputs after reset: ihit=0, imemload=0, iREN=0, iaddr=0.
- State machine, 2 states, IDLE and MISS:
  - IDLE:
    - hit = imemREN & valid[index] & (tag == stored tag); ihit = hit, combinational.
    - imemload = stored data when hit, else 0.
    - iREN=0.
    - On hit: hit_count += 1 at the edge.
    - If imemREN=1 and there is no hit: latch miss_addr = {imemaddr[31:2],2'b00}, miss_count += 1, go to MISS.
  - MISS:
    - iREN=1, iaddr=miss_addr, ihit=0, imemload=0.
    - Inputs imemaddr and imemREN are ignored; the fill always completes for the latched address.
    - When iwait=0: write line[miss_addr index] with valid=1, tag and data=iload; go to IDLE.
    - The refetch hits the following cycle if the CPU still presents that address.
  - iaddr = miss_addr in MISS; 0 in IDLE.
- Timing:
  - Hit latency is 0 cycles (combinational).
  - Miss penalty = cycles of iwait high + 2: one cycle to enter MISS, one to return to IDLE and hit.
- Conflict: a fill overwrites the indexed line unconditionally; there is no replacement choice.
- iflush:
  - At the edge, clear all valid bits, go to IDLE and discard any pending fill.
  - The line is not written even if iwait=0 in that same cycle.
  - In IDLE, ihit is forced to 0 during a cycle with iflush=1.
  - Counters are unaffected.
- imemREN=0 in IDLE: no state change, ihit=0.
- Counters: 32-bit wrap-around, no saturation.

Test Plan:
- Cold miss:
  - Stimulus: after reset, RAM word 0x10=0xDEADBEEF; imemREN=1, imemaddr=0x10.
  - Required: ihit=0; next cycle iREN=1, iaddr=0x10; after the fill, ihit=1 with imemload=0xDEADBEEF; miss_count=1, hit_count=1.
- Repeat hit:
  - Stimulus: hold 0x10 for 5 more cycles.
  - Required: ihit=1 every cycle, iREN never asserted, hit_count=6.
- Conflict eviction (SETS=16):
  - Stimulus: fetch 0x00 (data 0x11111111), then 0x40 (0x22222222), then 0x00.
  - Required: three misses (miss_count=3); final imemload=0x11111111.
- Address change mid-miss:
  - Stimulus: miss on 0x20; imemaddr switches to 0x24 while iwait=1.
  - Required: iaddr stays 0x20; line for 0x20 is filled; next cycle a miss on 0x24 is issued.
- Flush:
  - Stimulus: with 0x10 cached, pulse iflush=1 for one cycle, then fetch 0x10.
  - Required: ihit=0 during the flush cycle; afterwards a miss occurs (iREN=1, iaddr=0x10).
- Flush and reset mid-miss:
  - Stimulus: assert iflush in MISS on the same cycle iwait drops; separately, nRST=0 during MISS.
  - Required: no line written, state IDLE, iREN=0 next cycle; after reset, counters read 0.
